mantissa_align: RTL and testbench
=================================

MANTISSA_ALIGN -- requirements
Module: mantissa_align

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: the upstream operand pair and exponent difference are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-005 SHALL have ports SA, SB, input, 1 bit each: operand signs.
REQ-006 SHALL have ports EA, EB, input, 8 bits each: biased exponents.
REQ-007 SHALL have ports MA, MB, input, 8 bits each: significands with the hidden bit at bit 7.
REQ-008 SHALL have port diff, input, 8 bits: |EA-EB| from the exponent-difference stage.
REQ-009 SHALL have port EA_lt_EB, input, 1 bit: 1 when EA<EB.
REQ-010 SHALL have port out_valid, output, 1 bit: the aligned result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port e_big, output, 8 bits: the larger exponent.
REQ-013 SHALL have ports s_big, s_small, output, 1 bit each: the signs of the big and small operands.
REQ-014 SHALL have port m_big, output, 11 bits: {big significand, 3'b000}.
REQ-015 SHALL have port m_small, output, 11 bits: {aligned small significand, G, R, S}.
REQ-016 SHALL have port eff_sub, output, 1 bit: SA XOR SB.

Function
REQ-017 Transfer SHALL occur on an input when in_valid&&in_ready, and on an output when out_valid&&out_ready.
REQ-018 Operand selection: EA_lt_EB=0 selects A as big and B as small; EA_lt_EB=1 selects the reverse.
REQ-019 Equal exponents (diff=0, EA_lt_EB=0) SHALL select A as big with no shift.
REQ-020 Alignment SHALL form {m_small_in, 3'b000}, logically shift it right by diff, and OR every bit shifted out into bit 0 (sticky).
REQ-021 When diff>=11, m_small SHALL be 10'b0 followed by the OR of the small significand.
REQ-022 Latency SHALL be one cycle: a transfer accepted at edge N produces out_valid from edge N onward.
REQ-023 Output registers SHALL hold their value while out_valid && !out_ready, and data SHALL NOT change while stalled.
REQ-024 Simultaneous output and input transfer in the same cycle SHALL load the new result with no bubble; out_valid stays 1.
REQ-025 out_valid SHALL fall after an output transfer with no input transfer in the same cycle.
REQ-026 Without a skid buffer, in_ready SHALL equal !out_valid || out_ready.
REQ-027 The block SHALL NOT drop or duplicate any transaction under any in_valid/out_ready pattern.

Reset
REQ-028 While rst_n=0, out_valid SHALL be 0 and all data outputs 0, asynchronously.
REQ-029 A transaction held in the block when reset asserts SHALL be discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-031 Macro MANTISSA_ALIGN_SKID_EN defined SHALL add a one-entry skid register so that in_ready is a flop output equal to "skid empty".
REQ-032 With the macro defined, the skid entry SHALL capture an input accepted while the output is stalled and SHALL forward it to the output register before any newer input.
REQ-033 With the macro defined, throughput SHALL be 1 per cycle, latency still 1 cycle when unstalled, and at most 2 transactions SHALL be held.
REQ-034 With the macro undefined, REQ-026 applies and there SHALL be no skid storage.

Verification
REQ-035 Scenario: EA=0x85, EB=0x82, diff=3, EA_lt_EB=0, MA=0x80, MB=0xC1 -> e_big=0x85, m_big=0x400, m_small=0x0C1 (sticky 0).
REQ-036 Scenario: EA=0x70, EB=0x80, diff=16, EA_lt_EB=1, MA=0x81, MB=0x90 -> e_big=0x80, m_big=0x480, m_small=0x001.
REQ-037 Scenario: diff=0, SA=0, SB=1, MA=0xFF, MB=0xFF -> m_small=0x7F8, eff_sub=1, A selected as big.
REQ-038 Scenario: out_ready held 0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0 (without macro) or one extra input captured (with macro), then in-order drain.
REQ-039 Scenario: random in_valid/out_ready at 50% over 1000 transactions -> output sequence equals a reference model with no loss or duplication.
REQ-040 Scenario: rst_n pulsed low while out_valid=1 -> out_valid=0 immediately, and the next accepted input is the first output after reset.

Source files
------------

// File: rtl/mantissa_align.sv
// mantissa_align: selects big/small operand by exponent order and right-aligns the small
// significand with guard/round/sticky bits, behind a one-stage valid/ready register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake for SA, SB, EA, EB, MA, MB, diff, EA_lt_EB
//   out_valid / out_ready output handshake for e_big, s_big, s_small, m_big, m_small, eff_sub
// Optional feature: define MANTISSA_ALIGN_SKID_EN to add a one-entry skid register,
// making in_ready a registered "skid empty" flag.
module mantissa_align (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        SA,
   input  logic        SB,
   input  logic [7:0]  EA,
   input  logic [7:0]  EB,
   input  logic [7:0]  MA,
   input  logic [7:0]  MB,
   input  logic [7:0]  diff,
   input  logic        EA_lt_EB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  e_big,
   output logic        s_big,
   output logic        s_small,
   output logic [10:0] m_big,
   output logic [10:0] m_small,
   output logic        eff_sub
);
   typedef struct packed {
      logic [7:0]  e;
      logic        sb;
      logic        ss;
      logic [10:0] mb;
      logic [10:0] ms;
      logic        sub;
   } res_t;

   res_t        res_in, out_q, out_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  m_small_in;
   logic [10:0] m_ext;

   // Shifting the all-ones mask left by diff and inverting leaves exactly the bits
   // that fall off the right end; for diff >= 11 that is the whole word.
   always_comb begin
      m_small_in = EA_lt_EB ? MA : MB;
      m_ext      = {m_small_in, 3'b000};
      res_in.e   = EA_lt_EB ? EB : EA;
      res_in.sb  = EA_lt_EB ? SB : SA;
      res_in.ss  = EA_lt_EB ? SA : SB;
      res_in.mb  = {EA_lt_EB ? MB : MA, 3'b000};
      res_in.ms  = (m_ext >> diff) | {10'b0, |(m_ext & ~(11'h7FF << diff))};
      res_in.sub = SA ^ SB;
   end

`ifdef MANTISSA_ALIGN_SKID_EN
   res_t skid_q, skid_d;
   logic skid_valid_q, skid_valid_d;
   logic in_ready_q, in_ready_d;
   logic in_fire, out_load;

   assign in_ready = in_ready_q;

   // The output register refills from the skid entry first so order is preserved;
   // a new input lands in the skid entry only while the output is stalled.
   always_comb begin
      in_fire      = in_valid && in_ready_q;
      out_load     = !out_valid_q || out_ready;
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (out_load) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_d       = in_fire ? res_in : out_q;
            out_valid_d = in_fire;
         end
      end else if (in_fire) begin
         skid_d       = res_in;
         skid_valid_d = 1'b1;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
`else
   assign in_ready = !out_valid_q || out_ready;

   always_comb begin
      out_valid_d = in_ready ? in_valid : out_valid_q;
      out_d       = (in_valid && in_ready) ? res_in : out_q;
   end
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end

   assign out_valid = out_valid_q;
   assign {e_big, s_big, s_small, m_big, m_small, eff_sub} = out_q;
endmodule

// File: tb/tb_mantissa_align.sv
// tb_mantissa_align: randomized and directed checks of mantissa_align against an
// arithmetic reference model and a queue of in-flight transactions.
module tb_mantissa_align;
`ifdef MANTISSA_ALIGN_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  e;
      logic        sb;
      logic        ss;
      logic [10:0] mb;
      logic [10:0] ms;
      logic        sub;
   } res_t;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        SA = 1'b0, SB = 1'b0, EA_lt_EB = 1'b0;
   logic [7:0]  EA = '0, EB = '0, MA = '0, MB = '0, diff = '0;
   logic        in_ready, out_valid, s_big, s_small, eff_sub;
   logic [7:0]  e_big;
   logic [10:0] m_big, m_small;
   res_t        act;
   res_t        expq[$];
   int          checks = 0, errors = 0, pushes = 0, pops = 0;

   always #5 clk = ~clk;

   mantissa_align dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .SA(SA), .SB(SB), .EA(EA), .EB(EB), .MA(MA), .MB(MB), .diff(diff),
      .EA_lt_EB(EA_lt_EB), .out_valid(out_valid), .out_ready(out_ready),
      .e_big(e_big), .s_big(s_big), .s_small(s_small), .m_big(m_big),
      .m_small(m_small), .eff_sub(eff_sub)
   );

   assign act = {e_big, s_big, s_small, m_big, m_small, eff_sub};

   // Alignment as arithmetic: divide by 2^diff, sticky if any remainder.
   function automatic res_t model(input logic sa, sb, input logic [7:0] ea, eb, ma, mb, df,
                                  input logic lt);
      res_t r;
      int   v, p;
      v     = int'(lt ? ma : mb) * 8;
      r.e   = lt ? eb : ea;
      r.sb  = lt ? sb : sa;
      r.ss  = lt ? sa : sb;
      r.mb  = 11'(int'(lt ? mb : ma) * 8);
      r.sub = sa != sb;
      if (df >= 8'd11) r.ms = 11'(v != 0);
      else begin
         p    = 1 << df;
         r.ms = 11'((v / p) | (((v % p) != 0) ? 1 : 0));
      end
      return r;
   endfunction

   task automatic chk1(input string n, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
      end
   endtask

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   task automatic chk_res(input string n, input res_t a, input res_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got e=%h sb=%b ss=%b mb=%h ms=%h sub=%b expected e=%h sb=%b ss=%b mb=%h ms=%h sub=%b at %0t",
                  n, a.e, a.sb, a.ss, a.mb, a.ms, a.sub, e.e, e.sb, e.ss, e.mb, e.ms, e.sub, $time);
      end
   endtask

   // Compare process: the queue holds every accepted, not yet delivered transaction.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk1("rst_out_valid", out_valid, 1'b0);
         chk_res("rst_data", act, '0);
         expq.delete();
      end else begin
         chk1("out_valid", out_valid, expq.size() > 0);
         chk1("in_ready", in_ready, SKID ? (expq.size() < 2) : (expq.size() == 0 || out_ready));
         if (out_valid && expq.size() > 0) begin
            chk_res("data", act, expq[0]);
            if (out_ready) begin
               void'(expq.pop_front());
               pops++;
            end
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(SA, SB, EA, EB, MA, MB, diff, EA_lt_EB));
            pushes++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gen();
      logic [7:0] d;
      EA       = 8'($urandom);
      d        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      EB       = $urandom_range(0, 1) ? EA + d : EA - d;
      SA       = 1'($urandom);
      SB       = 1'($urandom);
      MA       = ($urandom_range(0, 15) == 0) ? 8'h00 : {1'b1, 7'($urandom)};
      MB       = ($urandom_range(0, 15) == 0) ? 8'h00 : {1'b1, 7'($urandom)};
      EA_lt_EB = EA < EB;
      diff     = EA_lt_EB ? EB - EA : EA - EB;
   endtask

   // Drives one transaction with out_ready=1 and checks DUT and model against literals.
   task automatic directed(input string n, input logic sa, sb, input logic [7:0] ea, eb, ma, mb,
                           df, input logic lt, input logic [7:0] xe, input logic [10:0] xmb, xms);
      res_t x;
      x = '{e: xe, sb: lt ? sb : sa, ss: lt ? sa : sb, mb: xmb, ms: xms, sub: sa ^ sb};
      SA = sa; SB = sb; EA = ea; EB = eb; MA = ma; MB = mb; diff = df; EA_lt_EB = lt;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      #1;
      chk1({n, "_valid"}, out_valid, 1'b1);
      chk_res({n, "_dut"}, act, x);
      chk_res({n, "_model"}, model(sa, sb, ea, eb, ma, mb, df, lt), x);
   endtask

   initial begin
      int   sent, cyc, nacc;
      logic acc;
      res_t hold;
      tick();
      tick();
      chk1("reset_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      #1 chk1("first_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      tick();

      directed("req035", 1'b0, 1'b0, 8'h85, 8'h82, 8'h80, 8'hC1, 8'd3, 1'b0, 8'h85, 11'h400, 11'h0C1);
      directed("req036", 1'b0, 1'b0, 8'h70, 8'h80, 8'h81, 8'h90, 8'd16, 1'b1, 8'h80, 11'h480, 11'h001);
      directed("req037", 1'b0, 1'b1, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'd0, 1'b0, 8'h7F, 11'h7F8, 11'h7F8);
      directed("diff4", 1'b1, 1'b0, 8'h90, 8'h8C, 8'h80, 8'h81, 8'd4, 1'b0, 8'h90, 11'h400, 11'h041);
      directed("diff10", 1'b1, 1'b1, 8'h00, 8'h0A, 8'hFF, 8'hA0, 8'd10, 1'b1, 8'h0A, 11'h500, 11'h001);
      directed("diff11z", 1'b0, 1'b1, 8'h20, 8'h15, 8'hC0, 8'h00, 8'd11, 1'b0, 8'h20, 11'h600, 11'h000);
      directed("diff11", 1'b0, 1'b0, 8'h20, 8'h15, 8'hC0, 8'h80, 8'd11, 1'b0, 8'h20, 11'h600, 11'h001);

      // Stall with in_valid held: one accept without skid, two with it.
      in_valid = 1'b0;
      tick();
      tick();
      out_ready = 1'b0;
      acc  = 1'b1;
      nacc = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (acc) gen();
         in_valid = 1'b1;
         #3;
         acc = in_ready;
         if (acc) nacc++;
         if (i == 2) hold = act;
         if (i == 4) chk_res("stall_stable", act, hold);
      end
      tick();
      chk("stall_accepts", nacc, SKID ? 2 : 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && expq.size() > 0; i++) tick();
      chk("stall_drain", expq.size(), 0);

      // Random traffic at 50% valid / 50% ready.
      sent = 0;
      cyc  = 0;
      acc  = 1'b1;
      while (sent < 1000 && cyc < 20000) begin
         tick();
         cyc++;
         if (acc || !in_valid) begin
            gen();
            in_valid = 1'($urandom);
         end
         out_ready = 1'($urandom);
         #3;
         acc = in_valid && in_ready;
         if (acc) sent++;
      end
      chk("random_sent", sent, 1000);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && expq.size() > 0; i++) tick();
      chk("random_drain", expq.size(), 0);
      chk("no_loss", pops, pushes);

      // Reset while holding a result; it must vanish at once.
      tick();
      gen();
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk1("pre_rst_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("async_rst_valid", out_valid, 1'b0);
      chk_res("async_rst_data", act, '0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk1("post_rst_in_ready", in_ready, 1'b1);
      chk1("post_rst_valid", out_valid, 1'b0);
      directed("post_rst", 1'b0, 1'b0, 8'h85, 8'h82, 8'h80, 8'hC1, 8'd3, 1'b0, 8'h85, 11'h400, 11'h0C1);
      tick();
      tick();
      chk("final_drain", expq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
